// File: rtl/rr_sound_sched_pkg.sv
// Shared constants, FSM encoding and width helper for the sound scheduler.
// Also intended for use by music_handler and rr_music.
package rr_sound_sched_pkg;

  localparam int unsigned NOTE_W = 8;

  localparam logic [NOTE_W-1:0] END_NOTE  = 8'hFF;
  localparam logic [NOTE_W-1:0] REST_NOTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Bit width needed to index n items; never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_tempo_tick.sv
// Note-step tempo counter: counts 0..TEMPO_DIV-1 while enabled, tick on the last count.
module rr_tempo_tick
  import rr_sound_sched_pkg::*;
#(
  parameter int unsigned TEMPO_DIV = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = width_of(TEMPO_DIV);
  localparam logic [CW-1:0] LAST = CW'(TEMPO_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rr_sound_sched.sv
// Music/SFX sequencer: steps ROM addresses at the tempo rate, handles end markers,
// lets higher-numbered SFX preempt music or lower SFX, and supports pause/stop.
module rr_sound_sched
  import rr_sound_sched_pkg::*;
#(
  parameter int unsigned TEMPO_DIV = 2**21,
  parameter int unsigned MUS_AW    = 10,
  parameter int unsigned SFX_AW    = 8,
  parameter int unsigned NUM_SFX   = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                play,
  input  logic                pause,
  input  logic [NUM_SFX-1:0]  sfx_req,
  input  logic [NOTE_W-1:0]   mus_note,
  input  logic [NOTE_W-1:0]   sfx_note,
  output logic [MUS_AW-1:0]   mus_addr,
  output logic [SFX_AW-1:0]   sfx_addr,
  output logic [NOTE_W-1:0]   note_out,
  output logic                sfx_busy,
  output logic                song_wrap,
  output logic                sfx_done
);

  localparam int unsigned ID_W  = width_of(NUM_SFX);
  localparam int unsigned OFF_W = SFX_AW - ID_W;

  state_t              state_q,     state_d;
  logic [MUS_AW-1:0]   mus_addr_q,  mus_addr_d;
  logic [ID_W-1:0]     sfx_id_q,    sfx_id_d;
  logic [OFF_W-1:0]    sfx_off_q,   sfx_off_d;
  logic                sfx_busy_q,  sfx_busy_d;
  logic [NOTE_W-1:0]   note_q,      note_d;
  logic [NOTE_W-1:0]   note_out_q,  note_out_d;
  logic                song_wrap_q, song_wrap_d;
  logic                sfx_done_q,  sfx_done_d;
  logic                lock_q,      lock_d;

  logic [ID_W-1:0]     req_id;
  logic                req_any;
  logic                accept;
  logic [NOTE_W-1:0]   cur_note;
  logic                tick;
  logic                tick_en;
  logic                tick_clr;

  // Highest set request bit wins.
  always_comb begin
    req_id  = '0;
    req_any = 1'b0;
    for (int unsigned i = 0; i < NUM_SFX; i++) begin
      if (sfx_req[i]) begin
        req_id  = ID_W'(i);
        req_any = 1'b1;
      end
    end
  end

  assign accept   = !pause && req_any && (!sfx_busy_q || (req_id > sfx_id_q));
  assign cur_note = sfx_busy_q ? sfx_note : mus_note;

  assign tick_en  = (state_q == ST_HOLD) && !pause;
  assign tick_clr = (state_d != ST_HOLD);

  rr_tempo_tick #(
    .TEMPO_DIV (TEMPO_DIV)
  ) u_tempo (
    .clock  (clock),
    .resetn (resetn),
    .en     (tick_en),
    .clr    (tick_clr),
    .tick   (tick)
  );

  // Priority: pause > SFX accept > play low > step/end-marker handling.
  always_comb begin
    state_d     = state_q;
    mus_addr_d  = mus_addr_q;
    sfx_id_d    = sfx_id_q;
    sfx_off_d   = sfx_off_q;
    sfx_busy_d  = sfx_busy_q;
    note_d      = note_q;
    note_out_d  = note_out_q;
    song_wrap_d = 1'b0;
    sfx_done_d  = 1'b0;
    lock_d      = lock_q;

    if (pause) begin
      note_out_d = REST_NOTE;
    end else begin
      lock_d = lock_q & play;
      if (accept) begin
        sfx_id_d   = req_id;
        sfx_off_d  = '0;
        sfx_busy_d = 1'b1;
        state_d    = ST_FETCH;
      end else if (!play && !sfx_busy_q) begin
        mus_addr_d = '0;
        if (state_q != ST_IDLE) begin
          state_d = ST_IDLE;
          note_d  = REST_NOTE;
        end
      end else begin
        if (!play) begin
          mus_addr_d = '0;
        end
        case (state_q)
          ST_IDLE: begin
            if (play && !lock_q) begin
              state_d = ST_FETCH;
            end
          end
          ST_FETCH: state_d = ST_WAIT;
          ST_WAIT:  state_d = ST_CHECK;
          ST_CHECK: begin
            if (cur_note != END_NOTE) begin
              note_d  = cur_note;
              state_d = ST_HOLD;
            end else if (sfx_busy_q) begin
              sfx_done_d = 1'b1;
              sfx_busy_d = 1'b0;
              if (play) begin
                state_d = ST_FETCH;
              end else begin
                state_d = ST_IDLE;
                note_d  = REST_NOTE;
              end
            end else if (mus_addr_q != '0) begin
              mus_addr_d  = '0;
              song_wrap_d = 1'b1;
              state_d     = ST_FETCH;
            end else begin
              // Empty song: park until play is re-asserted.
              note_d  = REST_NOTE;
              state_d = ST_IDLE;
              lock_d  = 1'b1;
            end
          end
          ST_HOLD: begin
            if (tick) begin
              if (sfx_busy_q) begin
                sfx_off_d = sfx_off_q + OFF_W'(1);
              end else begin
                mus_addr_d = mus_addr_q + MUS_AW'(1);
              end
              state_d = ST_FETCH;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      note_out_d = note_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mus_addr_q  <= '0;
      sfx_id_q    <= '0;
      sfx_off_q   <= '0;
      sfx_busy_q  <= 1'b0;
      note_q      <= REST_NOTE;
      note_out_q  <= REST_NOTE;
      song_wrap_q <= 1'b0;
      sfx_done_q  <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mus_addr_q  <= mus_addr_d;
      sfx_id_q    <= sfx_id_d;
      sfx_off_q   <= sfx_off_d;
      sfx_busy_q  <= sfx_busy_d;
      note_q      <= note_d;
      note_out_q  <= note_out_d;
      song_wrap_q <= song_wrap_d;
      sfx_done_q  <= sfx_done_d;
      lock_q      <= lock_d;
    end
  end

  assign mus_addr  = mus_addr_q;
  assign sfx_addr  = {sfx_id_q, sfx_off_q};
  assign note_out  = note_out_q;
  assign sfx_busy  = sfx_busy_q;
  assign song_wrap = song_wrap_q;
  assign sfx_done  = sfx_done_q;

endmodule

// File: tb/tb_rr_sound_sched.sv
// Scoreboard bench for rr_sound_sched: directed scenarios plus random play/pause/SFX traffic.
module tb_rr_sound_sched;

  localparam int TD   = 4;
  localparam int MAW  = 10;
  localparam int SAW  = 8;
  localparam int NS   = 4;
  localparam int OFFN = 64;

  logic          clock = 1'b0;
  logic          resetn;
  logic          play;
  logic          pause;
  logic [NS-1:0] sfx_req;
  logic [7:0]    mus_note;
  logic [7:0]    sfx_note;
  logic [MAW-1:0] mus_addr;
  logic [SAW-1:0] sfx_addr;
  logic [7:0]    note_out;
  logic          sfx_busy;
  logic          song_wrap;
  logic          sfx_done;

  rr_sound_sched #(
    .TEMPO_DIV (TD),
    .MUS_AW    (MAW),
    .SFX_AW    (SAW),
    .NUM_SFX   (NS)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .play      (play),
    .pause     (pause),
    .sfx_req   (sfx_req),
    .mus_note  (mus_note),
    .sfx_note  (sfx_note),
    .mus_addr  (mus_addr),
    .sfx_addr  (sfx_addr),
    .note_out  (note_out),
    .sfx_busy  (sfx_busy),
    .song_wrap (song_wrap),
    .sfx_done  (sfx_done)
  );

  always #5 clock = ~clock;

  logic [7:0] mus_rom [1024];
  logic [7:0] sfx_rom [256];

  // Block ROMs with one-cycle read latency.
  always @(posedge clock) begin
    mus_note <= mus_rom[mus_addr];
    sfx_note <= sfx_rom[sfx_addr];
  end

  typedef struct {
    logic [7:0]     note;
    logic [MAW-1:0] maddr;
    logic [SAW-1:0] saddr;
    logic           busy;
    logic           wrap;
    logic           done;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wrap_seen = 0;
  int done_seen = 0;

  logic          rstn_i, play_i, pause_i;
  logic [NS-1:0] req_i;

  // Reference model: "running" plus one step counter (0 fetch, 1 latency, 2 decide, 3.. hold beats).
  bit m_run, m_sfx, m_lock, m_wrap, m_done;
  int m_step, m_id, m_off, m_maddr, m_note, m_out;

  task automatic model_step();
    int win;
    logic [7:0] d;
    m_wrap = 0;
    m_done = 0;
    if (!rstn_i) begin
      m_run = 0; m_sfx = 0; m_lock = 0; m_step = 0; m_id = 0; m_off = 0;
      m_maddr = 0; m_note = 0; m_out = 0;
      return;
    end
    if (pause_i) begin
      m_out = 0;
      return;
    end
    win = -1;
    for (int i = 0; i < NS; i++) if (req_i[i]) win = i;
    if (win >= 0 && (!m_sfx || win > m_id)) begin
      m_sfx = 1; m_id = win; m_off = 0; m_run = 1; m_step = 0;
    end else if (!play_i && !m_sfx) begin
      m_maddr = 0;
      if (m_run) begin m_run = 0; m_note = 0; end
    end else begin
      if (!play_i) m_maddr = 0;
      if (!m_run) begin
        if (play_i && !m_lock) begin m_run = 1; m_step = 0; end
      end else if (m_step < 2) begin
        m_step++;
      end else if (m_step == 2) begin
        d = m_sfx ? sfx_rom[m_id * OFFN + m_off] : mus_rom[m_maddr];
        if (d != 8'hFF) begin
          m_note = d; m_step = 3;
        end else if (m_sfx) begin
          m_done = 1; m_sfx = 0;
          if (play_i) m_step = 0;
          else begin m_run = 0; m_note = 0; end
        end else if (m_maddr != 0) begin
          m_maddr = 0; m_wrap = 1; m_step = 0;
        end else begin
          m_note = 0; m_run = 0; m_lock = 1;
        end
      end else if (m_step - 3 == TD - 1) begin
        if (m_sfx) m_off = (m_off + 1) % OFFN;
        else m_maddr = (m_maddr + 1) % (1 << MAW);
        m_step = 0;
      end else begin
        m_step++;
      end
    end
    m_lock = m_lock && play_i;
    m_out = m_note;
  endtask

  // One clock: drive inputs, advance the model, queue its prediction, then settle past the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    resetn = rstn_i; play = play_i; pause = pause_i; sfx_req = req_i;
    model_step();
    e.note  = 8'(m_out);
    e.maddr = MAW'(m_maddr);
    e.saddr = SAW'(m_id * OFFN + m_off);
    e.busy  = m_sfx;
    e.wrap  = m_wrap;
    e.done  = m_done;
    exp_q.push_back(e);
    @(posedge clock);
    #2;
    if (song_wrap === 1'b1) wrap_seen++;
    if (sfx_done === 1'b1) done_seen++;
  endtask

  // Monitor: compare every registered output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (note_out !== e.note || mus_addr !== e.maddr || sfx_addr !== e.saddr ||
            sfx_busy !== e.busy || song_wrap !== e.wrap || sfx_done !== e.done) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t: got note=%h maddr=%h saddr=%h busy=%b wrap=%b done=%b, required note=%h maddr=%h saddr=%h busy=%b wrap=%b done=%b",
                   $time, note_out, mus_addr, sfx_addr, sfx_busy, song_wrap, sfx_done,
                   e.note, e.maddr, e.saddr, e.busy, e.wrap, e.done);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_note(input string name, input logic [7:0] v, input int max_cyc);
    bit hit = 0;
    for (int k = 0; k < max_cyc && !hit; k++) begin
      cycle();
      if (note_out === v) hit = 1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: note_out=%h, required %h within %0d cycles", name, note_out, v, max_cyc);
    end
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int start = done_seen;
    for (int k = 0; k < max_cyc && done_seen == start; k++) cycle();
    check(name, 32'(done_seen - start), 32'd1);
  endtask

  task automatic pulse_req(input logic [NS-1:0] r);
    req_i = r;
    cycle();
    req_i = '0;
  endtask

  task automatic load_song();
    for (int i = 0; i < 1024; i++) mus_rom[i] = 8'hFF;
    for (int i = 0; i < 256; i++) sfx_rom[i] = 8'hFF;
    mus_rom[0] = 8'h10; mus_rom[1] = 8'h20; mus_rom[2] = 8'h30;
    sfx_rom[64]  = 8'h55;
    sfx_rom[128] = 8'h88;
    sfx_rom[192] = 8'h77;
  endtask

  task automatic do_reset();
    rstn_i = 0;
    repeat (2) cycle();
    rstn_i = 1;
  endtask

  initial begin
    int len;
    rstn_i = 0; play_i = 0; pause_i = 0; req_i = '0;
    resetn = 0; play = 0; pause = 0; sfx_req = '0;
    load_song();
    do_reset();
    check("reset_outputs", {8'h0, note_out, 2'b0, mus_addr, sfx_addr, 5'b0, sfx_busy, song_wrap, sfx_done}, 32'h0);

    // Looping music with one wrap per loop.
    wrap_seen = 0;
    play_i = 1;
    expect_note("music_n0", 8'h10, 20);
    expect_note("music_n1", 8'h20, 20);
    expect_note("music_n2", 8'h30, 20);
    expect_note("music_loop", 8'h10, 20);
    check("wrap_once", 32'(wrap_seen), 32'd1);
    check("wrap_addr0", 32'(mus_addr), 32'd0);

    // SFX preempts music at address 2, music resumes there.
    expect_note("to_n1", 8'h20, 20);
    expect_note("to_n2", 8'h30, 20);
    check("music_at2", 32'(mus_addr), 32'd2);
    pulse_req(4'b0010);
    expect_note("sfx1_note", 8'h55, 20);
    wait_done("sfx1_done", 20);
    expect_note("resume_n2", 8'h30, 20);
    check("resume_addr", 32'(mus_addr), 32'd2);

    // Lower request dropped, higher one preempts.
    pulse_req(4'b0010);
    cycle();
    pulse_req(4'b0001);
    check("drop_low_busy", 32'(sfx_busy), 32'd1);
    check("drop_low_addr", 32'(sfx_addr), 32'h40);
    pulse_req(4'b1000);
    check("preempt_addr", 32'(sfx_addr), 32'hC0);
    expect_note("sfx3_note", 8'h77, 20);
    wait_done("sfx3_done", 20);

    // Same-cycle requests: SFX2 wins.
    pulse_req(4'b0110);
    check("prio_addr", 32'(sfx_addr), 32'h80);
    expect_note("sfx2_note", 8'h88, 20);
    wait_done("sfx2_done", 20);

    // Pause mid-hold.
    expect_note("pre_pause", 8'h20, 40);
    cycle();
    pause_i = 1;
    for (int k = 0; k < 20; k++) begin
      req_i = (k == 5) ? 4'b1000 : 4'b0000;
      cycle();
    end
    req_i = '0;
    check("pause_note", 32'(note_out), 32'h0);
    check("pause_addr", 32'(mus_addr), 32'd1);
    check("pause_no_sfx", 32'(sfx_busy), 32'd0);
    pause_i = 0;
    cycle();
    check("pause_restore", 32'(note_out), 32'h20);
    repeat (20) cycle();

    // Empty song.
    play_i = 0;
    do_reset();
    mus_rom[0] = 8'hFF;
    wrap_seen = 0;
    play_i = 1;
    repeat (15) cycle();
    check("empty_note", 32'(note_out), 32'h0);
    check("empty_nowrap", 32'(wrap_seen), 32'd0);

    // Reset in the middle of an SFX.
    play_i = 0;
    rstn_i = 0;
    load_song();
    cycle();
    rstn_i = 1;
    play_i = 1;
    expect_note("rst_pre", 8'h10, 20);
    pulse_req(4'b0100);
    repeat (3) cycle();
    check("rst_busy", 32'(sfx_busy), 32'd1);
    rstn_i = 0;
    cycle();
    check("rst_outputs", {8'h0, note_out, 2'b0, mus_addr, sfx_addr, 5'b0, sfx_busy, song_wrap, sfx_done}, 32'h0);
    rstn_i = 1;

    // Random traffic against the model.
    for (int r = 0; r < 8; r++) begin
      rstn_i = 0; pause_i = 0; req_i = '0;
      for (int i = 0; i < 1024; i++) mus_rom[i] = 8'hFF;
      for (int i = 0; i < 256; i++) sfx_rom[i] = 8'hFF;
      len = (r == 3) ? 0 : int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) mus_rom[i] = 8'($urandom_range(1, 254));
      for (int s = 0; s < NS; s++) begin
        len = int'($urandom_range(1, 3));
        for (int i = 0; i < len; i++) sfx_rom[s * OFFN + i] = 8'($urandom_range(1, 254));
      end
      repeat (2) cycle();
      rstn_i = 1;
      play_i = 1;
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 59) == 0) play_i = ~play_i;
        if (!pause_i && $urandom_range(0, 49) == 0) pause_i = 1;
        else if (pause_i && $urandom_range(0, 7) == 0) pause_i = 0;
        req_i = ($urandom_range(0, 24) == 0) ? NS'($urandom_range(1, 15)) : '0;
        cycle();
      end
    end

    req_i = '0; pause_i = 0;
    repeat (3) cycle();
    @(posedge clock);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
